// File: rtl/pixel_binarizer.sv
// rtl/pixel_binarizer.sv - multi-channel pixel threshold stage with per-frame foreground counter
//
// Purpose: thresholds CHANNELS packed samples against double-buffered LO/HI
// limits under one of four modes, and counts foreground pixels per frame.
//
// Ports:
//   iCLK, iRST        pixel clock, synchronous active-high reset
//   iDATA, iDVAL      input samples (channel 0 in the LSBs) and their valid
//   iSOF, iEOF        start / end of frame pulses (iEOF on the last pixel)
//   iTHRESH_LO/HI     threshold inputs, captured into shadow on iCFG_LD
//   iMODE             0=above, 1=below, 2=pass-through, 3=window
//   iCFG_LD           shadow register load strobe
//   oDATA, oDVAL      processed samples, 2 cycles after input
//   oFG_COUNT         foreground count of the last completed frame
//   oCNT_VALID        pulse when oFG_COUNT updates
//   oFRAME_CONT       completed frame counter (wraps)
//   oABORT            pulse when a frame is restarted without iEOF
module pixel_binarizer #(
  parameter int DATA_W     = 10,
  parameter int CHANNELS   = 3,
  parameter int DEFAULT_LO = 92,
  parameter int CNT_W      = 20
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic [CHANNELS*DATA_W-1:0] iDATA,
  input  logic                       iDVAL,
  input  logic                       iSOF,
  input  logic                       iEOF,
  input  logic [DATA_W-1:0]          iTHRESH_LO,
  input  logic [DATA_W-1:0]          iTHRESH_HI,
  input  logic [1:0]                 iMODE,
  input  logic                       iCFG_LD,
  output logic [CHANNELS*DATA_W-1:0] oDATA,
  output logic                       oDVAL,
  output logic [CNT_W-1:0]           oFG_COUNT,
  output logic                       oCNT_VALID,
  output logic [15:0]                oFRAME_CONT,
  output logic                       oABORT
);

  localparam logic [DATA_W-1:0] LO_RST = DATA_W'(DEFAULT_LO);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  // Shadow and active configuration
  logic [DATA_W-1:0] r_sh_lo, r_sh_hi, r_act_lo, r_act_hi;
  logic [1:0]        r_sh_mode, r_act_mode;

  // Configuration seen by the current pixel: on iSOF the new active value
  // applies immediately, with a same-cycle iCFG_LD bypassing the shadow.
  logic [DATA_W-1:0] w_lo, w_hi;
  logic [1:0]        w_mode;

  always_comb begin
    w_lo   = r_act_lo;
    w_hi   = r_act_hi;
    w_mode = r_act_mode;
    if (iSOF) begin
      if (iCFG_LD) begin
        w_lo   = iTHRESH_LO;
        w_hi   = iTHRESH_HI;
        w_mode = iMODE;
      end else begin
        w_lo   = r_sh_lo;
        w_hi   = r_sh_hi;
        w_mode = r_sh_mode;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_sh_lo    <= LO_RST;
      r_sh_hi    <= '1;
      r_sh_mode  <= 2'd0;
      r_act_lo   <= LO_RST;
      r_act_hi   <= '1;
      r_act_mode <= 2'd0;
    end else begin
      if (iCFG_LD) begin
        r_sh_lo   <= iTHRESH_LO;
        r_sh_hi   <= iTHRESH_HI;
        r_sh_mode <= iMODE;
      end
      if (iSOF) begin
        r_act_lo   <= w_lo;
        r_act_hi   <= w_hi;
        r_act_mode <= w_mode;
      end
    end
  end

  // Per-channel threshold rule; window mode yields zero when LO > HI
  // because no x can satisfy both bounds.
  logic [CHANNELS*DATA_W-1:0] w_res;
  logic                       w_fg;

  always_comb begin
    w_res = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (w_mode)
        2'd0: w_res[c*DATA_W +: DATA_W] = (iDATA[c*DATA_W +: DATA_W] > w_lo)  ? '1 : '0;
        2'd1: w_res[c*DATA_W +: DATA_W] = (iDATA[c*DATA_W +: DATA_W] <= w_lo) ? '1 : '0;
        2'd2: w_res[c*DATA_W +: DATA_W] = iDATA[c*DATA_W +: DATA_W];
        default: w_res[c*DATA_W +: DATA_W] =
                   ((iDATA[c*DATA_W +: DATA_W] >= w_lo) &&
                    (iDATA[c*DATA_W +: DATA_W] <= w_hi)) ? '1 : '0;
      endcase
    end
  end

  assign w_fg = |w_res[DATA_W-1:0];

  // Frame FSM and foreground counter
  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_s1_final;
  logic             r_s1_eof, r_s1_abort;
  logic [CNT_W-1:0] w_cnt_base, w_cnt_next;
  logic             w_cnt_en;

  // iSOF restarts the count with the pixel of the same cycle.
  always_comb begin
    w_cnt_base = iSOF ? '0 : r_count;
    w_cnt_en   = iDVAL && w_fg && (iSOF || (r_state == IN_FRAME));
    w_cnt_next = w_cnt_base;
    if (w_cnt_en && (w_cnt_base != {CNT_W{1'b1}}))
      w_cnt_next = w_cnt_base + 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_s1_final <= '0;
      r_s1_eof   <= 1'b0;
      r_s1_abort <= 1'b0;
    end else begin
      r_s1_eof   <= 1'b0;
      r_s1_abort <= 1'b0;
      r_count    <= w_cnt_next;
      case (r_state)
        IDLE: begin
          if (iSOF)
            r_state <= IN_FRAME;
        end
        default: begin
          if (iSOF) begin
            r_s1_abort <= 1'b1;
          end else if (iEOF) begin
            r_s1_eof   <= 1'b1;
            r_s1_final <= w_cnt_next;
            r_state    <= IDLE;
          end
        end
      endcase
    end
  end

  // Stage 1 data register
  logic [CHANNELS*DATA_W-1:0] r_s1_data;
  logic                       r_s1_dval;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_s1_data <= '0;
      r_s1_dval <= 1'b0;
    end else begin
      r_s1_dval <= iDVAL;
      if (iDVAL)
        r_s1_data <= w_res;
    end
  end

  // Stage 2: outputs, with frame events aligned to the last pixel's oDVAL
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oFG_COUNT   <= '0;
      oCNT_VALID  <= 1'b0;
      oFRAME_CONT <= '0;
      oABORT      <= 1'b0;
    end else begin
      oDVAL      <= r_s1_dval;
      oCNT_VALID <= r_s1_eof;
      oABORT     <= r_s1_abort;
      if (r_s1_dval)
        oDATA <= r_s1_data;
      if (r_s1_eof) begin
        oFG_COUNT   <= r_s1_final;
        oFRAME_CONT <= oFRAME_CONT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_binarizer.sv
// tb/tb_pixel_binarizer.sv - scoreboard bench for pixel_binarizer
module tb_pixel_binarizer;
  localparam int DW = 10;
  localparam int CH = 3;
  localparam int CW = 20;
  localparam int FULL = (1 << DW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, dval, sof, eof, cfg_ld;
  logic [CH*DW-1:0]  din;
  logic [DW-1:0]     tlo, thi;
  logic [1:0]        mode;

  logic [CH*DW-1:0]  a_data, b_data;
  logic              a_dval, a_cv, a_ab, b_dval, b_cv, b_ab;
  logic [CW-1:0]     a_cnt;
  logic [2:0]        b_cnt;
  logic [15:0]       a_fc, b_fc;

  pixel_binarizer #(.DATA_W(DW), .CHANNELS(CH), .DEFAULT_LO(92), .CNT_W(CW)) dut_a (
    .iCLK(clk), .iRST(rst), .iDATA(din), .iDVAL(dval), .iSOF(sof), .iEOF(eof),
    .iTHRESH_LO(tlo), .iTHRESH_HI(thi), .iMODE(mode), .iCFG_LD(cfg_ld),
    .oDATA(a_data), .oDVAL(a_dval), .oFG_COUNT(a_cnt), .oCNT_VALID(a_cv),
    .oFRAME_CONT(a_fc), .oABORT(a_ab));

  pixel_binarizer #(.DATA_W(DW), .CHANNELS(CH), .DEFAULT_LO(92), .CNT_W(3)) dut_b (
    .iCLK(clk), .iRST(rst), .iDATA(din), .iDVAL(dval), .iSOF(sof), .iEOF(eof),
    .iTHRESH_LO(tlo), .iTHRESH_HI(thi), .iMODE(mode), .iCFG_LD(cfg_ld),
    .oDATA(b_data), .oDVAL(b_dval), .oFG_COUNT(b_cnt), .oCNT_VALID(b_cv),
    .oFRAME_CONT(b_fc), .oABORT(b_ab));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int m_sh_lo, m_sh_hi, m_sh_mode, m_lo, m_hi, m_mode;
  bit m_in;
  int m_cnt, m_frames;

  logic [CH*DW-1:0] q_data[$];
  int               q_cnt[$];
  int               q_fc[$];
  int               q_abort[$];

  function automatic int rule(int x, int lo, int hi, int md);
    case (md)
      0: return (x > lo) ? FULL : 0;
      1: return (x <= lo) ? FULL : 0;
      2: return x;
      default: return (x >= lo && x <= hi) ? FULL : 0;
    endcase
  endfunction

  function automatic logic [CH*DW-1:0] pix(input int v);
    logic [CH*DW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_sh_lo = 92; m_sh_hi = FULL; m_sh_mode = 0;
    m_lo = 92;    m_hi = FULL;    m_mode = 0;
    m_in = 0; m_cnt = 0; m_frames = 0;
  endtask

  // Drive one clock of stimulus and advance the reference model.
  task automatic cycle(input bit s, input bit e, input bit v, input logic [CH*DW-1:0] d,
                       input bit ld, input int lo, input int hi, input int md);
    logic [CH*DW-1:0] exp;
    sof = s; eof = e; dval = v; din = d; cfg_ld = ld;
    tlo = DW'(lo); thi = DW'(hi); mode = 2'(md);
    if (s) begin
      m_lo   = ld ? lo : m_sh_lo;
      m_hi   = ld ? hi : m_sh_hi;
      m_mode = ld ? md : m_sh_mode;
    end
    if (ld) begin
      m_sh_lo = lo; m_sh_hi = hi; m_sh_mode = md;
    end
    if (s) begin
      if (m_in) q_abort.push_back(1);
      m_in  = 1;
      m_cnt = 0;
    end
    if (v) begin
      for (int c = 0; c < CH; c++)
        exp[c*DW +: DW] = DW'(rule(int'(d[c*DW +: DW]), m_lo, m_hi, m_mode));
      q_data.push_back(exp);
      if (m_in && exp[DW-1:0] != 0) m_cnt++;
    end
    if (e && !s && m_in) begin
      m_frames++;
      q_cnt.push_back(m_cnt);
      q_fc.push_back(m_frames);
      m_in = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event
  always @(negedge clk) begin
    if (!rst) begin
      if (a_dval) begin
        if (q_data.size() == 0) chk("unexpected_odval", 32'(a_dval), 32'd0);
        else chk("odata", 32'(a_data), 32'(q_data.pop_front()));
      end
      if (a_cv || b_cv) begin
        chk("cnt_valid_pair", {31'd0, b_cv}, {31'd0, a_cv});
        if (q_cnt.size() == 0) chk("unexpected_cnt_valid", 32'd1, 32'd0);
        else begin
          int c;
          c = q_cnt.pop_front();
          chk("fg_count", 32'(a_cnt), 32'(imin(c, (1 << CW) - 1)));
          chk("fg_count_sat3", 32'(b_cnt), 32'(imin(c, 7)));
          chk("frame_cont", 32'(a_fc), 32'(q_fc.pop_front() & 16'hFFFF));
        end
      end
      if (a_ab) begin
        if (q_abort.size() == 0) chk("unexpected_abort", 32'd1, 32'd0);
        else void'(q_abort.pop_front());
      end
    end
  end

  function automatic logic [CH*DW-1:0] rnd_px();
    logic [CH*DW-1:0] r;
    int v;
    for (int c = 0; c < CH; c++) begin
      case ($urandom_range(0, 5))
        0: v = m_sh_lo;
        1: v = m_sh_lo + 1;
        2: v = m_sh_hi;
        3: v = m_sh_hi + 1;
        default: v = $urandom_range(0, FULL);
      endcase
      r[c*DW +: DW] = DW'(v & FULL);
    end
    return r;
  endfunction

  initial begin
    rst = 1; sof = 0; eof = 0; dval = 0; din = '0; cfg_ld = 0;
    tlo = '0; thi = '0; mode = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_odata", 32'(a_data), 32'd0);
    chk("rst_odval", 32'(a_dval), 32'd0);
    chk("rst_count", 32'(a_cnt), 32'd0);
    chk("rst_cv", 32'(a_cv), 32'd0);
    chk("rst_fc", 32'(a_fc), 32'd0);
    chk("rst_abort", 32'(a_ab), 32'd0);
    rst = 0;

    // Default mode 0, LO=92
    cycle(1, 0, 1, pix(92), 0, 0, 0, 0);
    cycle(0, 0, 1, pix(93), 0, 0, 0, 0);
    cycle(0, 1, 1, pix(FULL), 0, 0, 0, 0);
    idle(3);
    chk("t1_count", 32'(a_cnt), 32'd2);
    chk("t1_frames", 32'(a_fc), 32'd1);

    // Mid-frame config load takes effect at the next frame only
    cycle(1, 0, 1, pix(50), 0, 0, 0, 0);
    cycle(0, 0, 1, pix(150), 1, 100, 200, 3);
    cycle(0, 1, 1, pix(50), 0, 0, 0, 0);
    idle(1);
    cycle(1, 0, 1, pix(99), 0, 0, 0, 0);
    cycle(0, 0, 1, pix(100), 0, 0, 0, 0);
    cycle(0, 0, 1, pix(200), 0, 0, 0, 0);
    cycle(0, 1, 1, pix(201), 0, 0, 0, 0);
    idle(3);
    chk("t2_count", 32'(a_cnt), 32'd2);

    // Load coincident with SOF bypasses the shadow
    cycle(1, 0, 1, pix(5), 1, 10, 0, 1);
    cycle(0, 1, 1, pix(20), 0, 0, 0, 0);
    idle(3);
    chk("t3_count", 32'(a_cnt), 32'd1);

    // Abort: 10 foreground pixels, restart, then 4 foreground pixels
    cycle(1, 0, 1, pix(3), 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, pix(3), 0, 0, 0, 0);
    cycle(1, 0, 1, pix(3), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, pix(3), 0, 0, 0, 0);
    cycle(0, 0, 1, pix(50), 0, 0, 0, 0);
    cycle(0, 1, 1, pix(50), 0, 0, 0, 0);
    idle(3);
    chk("t4_count", 32'(a_cnt), 32'd4);
    chk("t4_frames", 32'(a_fc), 32'd5);

    // Saturation of the narrow counter
    cycle(1, 0, 1, pix(3), 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, pix(3), 0, 0, 0, 0);
    cycle(0, 1, 1, pix(3), 0, 0, 0, 0);
    idle(3);
    chk("t5_count", 32'(a_cnt), 32'd12);
    chk("t5_sat", 32'(b_cnt), 32'd7);

    // Pass-through
    cycle(1, 0, 1, pix(12'h155), 1, 0, 0, 2);
    cycle(0, 1, 1, pix(0), 0, 0, 0, 0);
    idle(3);
    chk("t6_count", 32'(a_cnt), 32'd1);

    // Reset in the middle of a frame
    cycle(1, 0, 1, pix(7), 0, 0, 0, 0);
    cycle(0, 0, 1, pix(9), 0, 0, 0, 0);
    idle(3);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_odata", 32'(a_data), 32'd0);
    chk("mid_rst_fc", 32'(a_fc), 32'd0);
    chk("mid_rst_count", 32'(a_cnt), 32'd0);
    chk("mid_rst_pulses", {30'd0, a_cv, a_ab}, 32'd0);
    rst = 0;
    model_reset();

    // Stray EOF in IDLE, with default config restored
    cycle(0, 1, 1, pix(93), 0, 0, 0, 0);
    idle(4);
    chk("stray_eof_fc", 32'(a_fc), 32'd0);

    // Randomized frames
    for (int f = 0; f < 70; f++) begin
      int len;
      if ($urandom_range(0, 2) == 0) begin
        int lo, hi;
        lo = $urandom_range(0, FULL);
        hi = $urandom_range(0, FULL);
        cycle(0, 0, $urandom_range(0, 1), rnd_px(), 1, lo, hi, $urandom_range(0, 3));
      end
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        bit s, e, ld;
        s  = (i == 0) || ($urandom_range(0, 40) == 0);
        e  = (i == len - 1);
        ld = ($urandom_range(0, 15) == 0);
        cycle(s, e, $urandom_range(0, 3) != 0, rnd_px(), ld,
              $urandom_range(0, FULL), $urandom_range(0, FULL), $urandom_range(0, 3));
      end
      for (int i = 0; i < $urandom_range(0, 3); i++)
        cycle(0, $urandom_range(0, 4) == 0, $urandom_range(0, 1), rnd_px(), 0, 0, 0, 0);
    end
    idle(5);
    chk("q_data_empty", 32'(q_data.size()), 32'd0);
    chk("q_cnt_empty", 32'(q_cnt.size()), 32'd0);
    chk("q_abort_empty", 32'(q_abort.size()), 32'd0);
    chk("final_frames", 32'(a_fc), 32'(m_frames & 16'hFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
